// File: rtl/ad_ip_jesd204_tpl_dac_sync_ctrl.sv
// Start-up sequencer for the TPL DAC datapath: arm on dac_sync, optional external trigger, then a link-ready delay.
// Define TPL_DAC_SYNC_TIMEOUT_EN to build the ARMED-state timeout counter.
module ad_ip_jesd204_tpl_dac_sync_ctrl #(
  parameter int EXT_SYNC       = 0,
  parameter int DELAY_WIDTH    = 16,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   dac_sync,
  input  logic                   dac_sync_in,
  input  logic                   ext_sync_enable,
  input  logic [DELAY_WIDTH-1:0] start_delay,
  input  logic                   link_ready,
  output logic                   sync_arm,
  output logic                   sync_armed,
  output logic                   sync_timeout,
  output logic [1:0]             state,
  output logic [COUNT_WIDTH-1:0] trigger_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DELAY = 2'd2,
    ST_RUN   = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic                   sync_arm_q, sync_arm_d;
  logic                   sync_armed_q, sync_armed_d;
  logic                   sync_timeout_q, sync_timeout_d;
  logic [COUNT_WIDTH-1:0] trigger_count_q, trigger_count_d;
  logic [DELAY_WIDTH-1:0] cnt_q, cnt_d;
  logic                   dac_sync_d1_q, dac_sync_in_d1_q;
  logic                   dac_sync_rise, dac_sync_in_rise;
  logic                   ext_path, accept;

`ifdef TPL_DAC_SYNC_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] tcnt_q, tcnt_d;
`endif

  assign dac_sync_rise    = dac_sync & ~dac_sync_d1_q;
  assign dac_sync_in_rise = dac_sync_in & ~dac_sync_in_d1_q;
  assign ext_path         = (EXT_SYNC != 0) && ext_sync_enable;

  always_comb begin
    state_d         = state_q;
    sync_timeout_d  = sync_timeout_q;
    trigger_count_d = trigger_count_q;
    cnt_d           = cnt_q;
    accept          = 1'b0;
`ifdef TPL_DAC_SYNC_TIMEOUT_EN
    tcnt_d          = tcnt_q;
`endif
    // A new software request restarts from any state and masks a same-cycle trigger edge.
    if (dac_sync_rise) begin
      sync_timeout_d = 1'b0;
      if (ext_path) begin
        state_d = ST_ARMED;
`ifdef TPL_DAC_SYNC_TIMEOUT_EN
        tcnt_d  = '0;
`endif
      end else begin
        accept = 1'b1;
      end
    end else begin
      case (state_q)
        ST_ARMED: begin
          if (dac_sync_in_rise) begin
            accept = 1'b1;
          end
`ifdef TPL_DAC_SYNC_TIMEOUT_EN
          else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_d        = ST_RUN;
            sync_timeout_d = 1'b1;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
`endif
        end
        ST_DELAY: begin
          if (link_ready) begin
            cnt_d = cnt_q - DELAY_WIDTH'(1);
            if (cnt_q == DELAY_WIDTH'(1)) begin
              state_d = ST_RUN;
            end
          end
        end
        default: begin
        end
      endcase
    end

    if (accept) begin
      if (start_delay == '0) begin
        state_d = ST_RUN;
      end else begin
        state_d = ST_DELAY;
        cnt_d   = start_delay;
      end
      if (trigger_count_q != '1) begin
        trigger_count_d = trigger_count_q + COUNT_WIDTH'(1);
      end
    end

    sync_arm_d   = (state_d == ST_ARMED) || (state_d == ST_DELAY);
    sync_armed_d = (state_d == ST_ARMED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      sync_arm_q       <= 1'b0;
      sync_armed_q     <= 1'b0;
      sync_timeout_q   <= 1'b0;
      trigger_count_q  <= '0;
      cnt_q            <= '0;
      dac_sync_d1_q    <= 1'b0;
      dac_sync_in_d1_q <= 1'b0;
`ifdef TPL_DAC_SYNC_TIMEOUT_EN
      tcnt_q           <= '0;
`endif
    end else begin
      state_q          <= state_d;
      sync_arm_q       <= sync_arm_d;
      sync_armed_q     <= sync_armed_d;
      sync_timeout_q   <= sync_timeout_d;
      trigger_count_q  <= trigger_count_d;
      cnt_q            <= cnt_d;
      dac_sync_d1_q    <= dac_sync;
      dac_sync_in_d1_q <= dac_sync_in;
`ifdef TPL_DAC_SYNC_TIMEOUT_EN
      tcnt_q           <= tcnt_d;
`endif
    end
  end

  assign sync_arm      = sync_arm_q;
  assign sync_armed    = sync_armed_q;
  assign sync_timeout  = sync_timeout_q;
  assign state         = state_q;
  assign trigger_count = trigger_count_q;

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_dac_sync_ctrl.sv
// Bench for the TPL DAC sync controller: an EXT_SYNC=1 unit under full test and an EXT_SYNC=0 unit sharing inputs.
module tb_ad_ip_jesd204_tpl_dac_sync_ctrl;

  localparam int DW = 8;
  localparam int CW = 4;
  localparam int TO = 16;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          dac_sync = 1'b0;
  logic          dac_sync_in = 1'b0;
  logic          ext_sync_enable = 1'b0;
  logic [DW-1:0] start_delay = '0;
  logic          link_ready = 1'b1;

  logic          sync_arm, sync_armed, sync_timeout;
  logic [1:0]    state;
  logic [CW-1:0] trigger_count;
  logic          sync_arm0, sync_armed0, sync_timeout0;
  logic [1:0]    state0;
  logic [CW-1:0] trigger_count0;

  int checks = 0;
  int passes = 0;
  int exp_cnt = 0;

  ad_ip_jesd204_tpl_dac_sync_ctrl #(
    .EXT_SYNC(1), .DELAY_WIDTH(DW), .TIMEOUT_CYCLES(TO), .COUNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset), .dac_sync(dac_sync), .dac_sync_in(dac_sync_in),
    .ext_sync_enable(ext_sync_enable), .start_delay(start_delay), .link_ready(link_ready),
    .sync_arm(sync_arm), .sync_armed(sync_armed), .sync_timeout(sync_timeout),
    .state(state), .trigger_count(trigger_count)
  );

  ad_ip_jesd204_tpl_dac_sync_ctrl #(
    .EXT_SYNC(0), .DELAY_WIDTH(DW), .TIMEOUT_CYCLES(TO), .COUNT_WIDTH(CW)
  ) dut0 (
    .clk(clk), .reset(reset), .dac_sync(dac_sync), .dac_sync_in(dac_sync_in),
    .ext_sync_enable(ext_sync_enable), .start_delay(start_delay), .link_ready(link_ready),
    .sync_arm(sync_arm0), .sync_armed(sync_armed0), .sync_timeout(sync_timeout0),
    .state(state0), .trigger_count(trigger_count0)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat_inc(int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  // Reference: after an accepted trigger with delay D, the hold lasts until D link-ready beats have been seen.
  task automatic follow_delay(int d, bit rnd, string nm);
    int rem = d;
    int guard = 0;
    checks++; if (sync_arm !== (rem > 0)) $display("FAIL %s_arm0: got %0d exp %0d", nm, sync_arm, rem > 0); else passes++;
    checks++; if (state !== ((rem > 0) ? 2'd2 : 2'd3)) $display("FAIL %s_state0: got %0d exp %0d", nm, state, (rem > 0) ? 2 : 3); else passes++;
    while (rem > 0 && guard < 300) begin
      link_ready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start_delay = DW'($urandom_range(0, 255));
      tick();
      guard++;
      if (link_ready) rem--;
      checks++; if (sync_arm !== (rem > 0)) $display("FAIL %s_arm: got %0d exp %0d rem %0d", nm, sync_arm, rem > 0, rem); else passes++;
      checks++; if (state !== ((rem > 0) ? 2'd2 : 2'd3)) $display("FAIL %s_state: got %0d exp %0d", nm, state, (rem > 0) ? 2 : 3); else passes++;
    end
    if (rem > 0) begin
      checks++; $display("FAIL %s_bound: delay not finished, rem %0d exp 0", nm, rem);
    end
    link_ready = 1'b1;
    checks++; if (trigger_count !== CW'(exp_cnt)) $display("FAIL %s_count: got %0d exp %0d", nm, trigger_count, exp_cnt); else passes++;
  endtask

  task automatic trig_internal(int d, bit rnd, string nm);
    ext_sync_enable = 1'b0;
    dac_sync = 1'b0; tick();
    start_delay = DW'(d); dac_sync = 1'b1; tick(); dac_sync = 1'b0;
    exp_cnt = sat_inc(exp_cnt);
    follow_delay(d, rnd, nm);
  endtask

  task automatic test_reset();
    reset = 1'b1; tick(); tick(); tick();
    checks++; if (state !== 2'd0) $display("FAIL rst_state: got %0d exp 0", state); else passes++;
    checks++; if (sync_arm !== 1'b0) $display("FAIL rst_arm: got %0d exp 0", sync_arm); else passes++;
    checks++; if (sync_armed !== 1'b0) $display("FAIL rst_armed: got %0d exp 0", sync_armed); else passes++;
    checks++; if (sync_timeout !== 1'b0) $display("FAIL rst_timeout: got %0d exp 0", sync_timeout); else passes++;
    checks++; if (trigger_count !== '0) $display("FAIL rst_count: got %0d exp 0", trigger_count); else passes++;
    reset = 1'b0; tick();
    exp_cnt = 0;
  endtask

  task automatic test_internal();
    trig_internal(4, 1'b0, "int_d4");
    trig_internal(0, 1'b0, "int_d0");
    trig_internal(1, 1'b0, "int_d1");
  endtask

  task automatic test_link_pause();
    logic pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    int held = 1;
    dac_sync = 1'b0; tick();
    start_delay = DW'(3); dac_sync = 1'b1; tick(); dac_sync = 1'b0;
    exp_cnt = sat_inc(exp_cnt);
    for (int i = 0; i < 5; i++) begin
      link_ready = pat[i];
      tick();
      if (sync_arm) held++;
    end
    link_ready = 1'b1;
    checks++; if (held !== 5) $display("FAIL pause_held: got %0d exp 5", held); else passes++;
    checks++; if (state !== 2'd3) $display("FAIL pause_state: got %0d exp 3", state); else passes++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++) begin
      trig_internal($urandom_range(0, 12), 1'b1, "rnd");
    end
  endtask

  task automatic test_ext();
    int wait_n;
    ext_sync_enable = 1'b1;
    dac_sync = 1'b0; dac_sync_in = 1'b0; tick();
    start_delay = DW'(5); dac_sync = 1'b1; tick(); dac_sync = 1'b0;
    checks++; if (state !== 2'd1) $display("FAIL ext_state: got %0d exp 1", state); else passes++;
    checks++; if (sync_armed !== 1'b1) $display("FAIL ext_armed: got %0d exp 1", sync_armed); else passes++;
    checks++; if (sync_arm !== 1'b1) $display("FAIL ext_arm: got %0d exp 1", sync_arm); else passes++;
    checks++; if (state0 !== 2'd2) $display("FAIL noext_state: got %0d exp 2", state0); else passes++;
    checks++; if (sync_armed0 !== 1'b0) $display("FAIL noext_armed: got %0d exp 0", sync_armed0); else passes++;
    for (int i = 0; i < 9; i++) tick();
    start_delay = '0; dac_sync_in = 1'b1; tick(); dac_sync_in = 1'b0;
    exp_cnt = sat_inc(exp_cnt);
    checks++; if (state !== 2'd3) $display("FAIL ext_trig_state: got %0d exp 3", state); else passes++;
    checks++; if (sync_arm !== 1'b0) $display("FAIL ext_trig_arm: got %0d exp 0", sync_arm); else passes++;
    checks++; if (sync_armed !== 1'b0) $display("FAIL ext_trig_armed: got %0d exp 0", sync_armed); else passes++;
    checks++; if (trigger_count !== CW'(exp_cnt)) $display("FAIL ext_trig_count: got %0d exp %0d", trigger_count, exp_cnt); else passes++;
    for (int i = 0; i < 4; i++) begin
      int d = $urandom_range(1, 9);
      wait_n = $urandom_range(0, 6);
      tick();
      dac_sync = 1'b1; tick(); dac_sync = 1'b0;
      for (int k = 0; k < wait_n; k++) tick();
      checks++; if (state !== 2'd1) $display("FAIL ext_rnd_wait: got %0d exp 1", state); else passes++;
      start_delay = DW'(d); dac_sync_in = 1'b1; tick(); dac_sync_in = 1'b0;
      exp_cnt = sat_inc(exp_cnt);
      follow_delay(d, 1'b1, "ext_rnd");
    end
  endtask

  task automatic test_simultaneous();
    ext_sync_enable = 1'b1;
    tick();
    dac_sync = 1'b1; dac_sync_in = 1'b1; tick();
    dac_sync = 1'b0; dac_sync_in = 1'b0;
    checks++; if (state !== 2'd1) $display("FAIL simul_state: got %0d exp 1", state); else passes++;
    checks++; if (trigger_count !== CW'(exp_cnt)) $display("FAIL simul_count: got %0d exp %0d", trigger_count, exp_cnt); else passes++;
    // Enable dropped while armed: must keep waiting for the trigger.
    tick(); ext_sync_enable = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    checks++; if (state !== 2'd1) $display("FAIL drop_en_state: got %0d exp 1", state); else passes++;
    start_delay = '0; dac_sync_in = 1'b1; tick(); dac_sync_in = 1'b0;
    exp_cnt = sat_inc(exp_cnt);
    checks++; if (state !== 2'd3) $display("FAIL drop_en_trig: got %0d exp 3", state); else passes++;
  endtask

  task automatic test_restart();
    ext_sync_enable = 1'b0;
    dac_sync = 1'b0; tick();
    start_delay = DW'(10); dac_sync = 1'b1; tick(); dac_sync = 1'b0;
    exp_cnt = sat_inc(exp_cnt);
    tick(); tick(); tick();
    start_delay = DW'(2); dac_sync = 1'b1; tick(); dac_sync = 1'b0;
    exp_cnt = sat_inc(exp_cnt);
    follow_delay(2, 1'b0, "restart");
  endtask

  task automatic test_timeout();
    int armed_n = 0;
    ext_sync_enable = 1'b1;
    dac_sync = 1'b0; tick();
    dac_sync = 1'b1; tick(); dac_sync = 1'b0;
`ifdef TPL_DAC_SYNC_TIMEOUT_EN
    while (state === 2'd1 && armed_n < 100) begin
      armed_n++;
      tick();
    end
    checks++; if (armed_n !== TO) $display("FAIL to_cycles: got %0d exp %0d", armed_n, TO); else passes++;
    checks++; if (state !== 2'd3) $display("FAIL to_state: got %0d exp 3", state); else passes++;
    checks++; if (sync_timeout !== 1'b1) $display("FAIL to_flag: got %0d exp 1", sync_timeout); else passes++;
    checks++; if (sync_arm !== 1'b0) $display("FAIL to_arm: got %0d exp 0", sync_arm); else passes++;
    checks++; if (trigger_count !== CW'(exp_cnt)) $display("FAIL to_count: got %0d exp %0d", trigger_count, exp_cnt); else passes++;
    dac_sync = 1'b1; tick(); dac_sync = 1'b0;
    checks++; if (sync_timeout !== 1'b0) $display("FAIL to_clear: got %0d exp 0", sync_timeout); else passes++;
`else
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (state === 2'd1 && sync_timeout === 1'b0) armed_n++;
    end
    checks++; if (armed_n !== 1000) $display("FAIL noto_wait: got %0d exp 1000", armed_n); else passes++;
`endif
    checks++; if (state !== 2'd1) $display("FAIL to_rearm: got %0d exp 1", state); else passes++;
    start_delay = '0; dac_sync_in = 1'b1; tick(); dac_sync_in = 1'b0;
    exp_cnt = sat_inc(exp_cnt);
    checks++; if (state !== 2'd3) $display("FAIL to_exit: got %0d exp 3", state); else passes++;
  endtask

  task automatic test_saturate();
    ext_sync_enable = 1'b0; start_delay = '0;
    for (int i = 0; i < CMAX + 3; i++) begin
      dac_sync = 1'b1; tick();
      dac_sync = 1'b0; tick();
      exp_cnt = sat_inc(exp_cnt);
    end
    checks++; if (trigger_count !== CW'(CMAX)) $display("FAIL sat_count: got %0d exp %0d", trigger_count, CMAX); else passes++;
  endtask

  task automatic test_reset_mid();
    ext_sync_enable = 1'b0;
    dac_sync = 1'b0; tick();
    start_delay = DW'(12); dac_sync = 1'b1; tick(); dac_sync = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    checks++; if (state !== 2'd2) $display("FAIL mid_pre_state: got %0d exp 2", state); else passes++;
    reset = 1'b1; tick();
    checks++; if (state !== 2'd0) $display("FAIL mid_state: got %0d exp 0", state); else passes++;
    checks++; if (sync_arm !== 1'b0) $display("FAIL mid_arm: got %0d exp 0", sync_arm); else passes++;
    checks++; if (trigger_count !== '0) $display("FAIL mid_count: got %0d exp 0", trigger_count); else passes++;
    // Input already high when reset releases must register as a rising edge.
    dac_sync = 1'b1; start_delay = '0; tick();
    reset = 1'b0; tick();
    checks++; if (state !== 2'd3) $display("FAIL post_rst_edge_state: got %0d exp 3", state); else passes++;
    checks++; if (trigger_count !== CW'(1)) $display("FAIL post_rst_edge_count: got %0d exp 1", trigger_count); else passes++;
    dac_sync = 1'b0; tick();
    exp_cnt = 1;
  endtask

  initial begin
    test_reset();
    test_internal();
    test_link_pause();
    test_random();
    test_ext();
    test_simultaneous();
    test_restart();
    test_timeout();
    test_saturate();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
